hazard_ctrl: RTL and testbench

Central pipeline hazard controller that sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.
- Drives each register's 2-bit HzCtrl input: 00 normal, 01 flush, 10 stall.
- Detects load-use, taken-branch, jump, multi-cycle mult/div and data-memory-wait conditions.
- Tracks mult/div occupancy with an internal FSM and counter; counts stall cycles for performance monitoring.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_ctrl_md_occupancy_cnt.sv | 29 ++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard-control encodings and FSM state type.
package hazard_ctrl_pkg;

  // Width of the mult/div occupancy counter; covers latencies up to 63.
  localparam int unsigned MD_CNT_W = 6;

  typedef logic [1:0] hz_t;

  localparam hz_t HZ_NORMAL = 2'b00;
  localparam hz_t HZ_FLUSH  = 2'b01;
  localparam hz_t HZ_STALL  = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard detection inputs from the pipeline and HzCtrl outputs back to it.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [4:0] id_rs_addr;
  logic [4:0] id_rt_addr;
  logic       id_uses_rt;
  logic       ex_mem_rd;
  logic [4:0] ex_rt_addr;
  logic       ex_branch_taken;
  logic       id_jump;
  logic       ex_md_start;
  logic       mem_wait;

  hz_t        pc_hz;
  hz_t        if_id_hz;
  hz_t        id_ex_hz;
  hz_t        ex_mem_hz;

  // Pipeline side: reports hazard conditions, consumes controls.
  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_rd, ex_rt_addr,
           ex_branch_taken, id_jump, ex_md_start, mem_wait,
    input  pc_hz, if_id_hz, id_ex_hz, ex_mem_hz
  );

  // Controller side.
  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_rd, ex_rt_addr,
           ex_branch_taken, id_jump, ex_md_start, mem_wait,
    output pc_hz, if_id_hz, id_ex_hz, ex_mem_hz
  );

endinterface

// File: rtl/hazard_ctrl_md_occupancy_cnt.sv
// Down-counter tracking remaining mult/div EX cycles.
module md_occupancy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero_c
);

  logic [MD_CNT_W-1:0] cnt;

  // Load latency-1 on start, otherwise count down while requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= MD_CNT_W'(MD_LATENCY - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - MD_CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch, jump, mult/div and memory-wait sequencing.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz_if,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  md_state_e state;
  logic      md_zero;
  logic      md_load;
  logic      md_dec;
  logic      md_stall;
  logic      branch_eff;
  logic      load_use;
  hz_t       pc_hz_c;
  hz_t       if_id_hz_c;
  hz_t       id_ex_hz_c;
  hz_t       ex_mem_hz_c;

  // Start is only accepted when memory is not freezing the pipe; branches
  // and starts seen while busy belong to the held instruction and are ignored.
  assign md_load    = (state == RUN) && hz_if.ex_md_start && !hz_if.mem_wait;
  assign md_dec     = (state == MD_BUSY);
  assign md_stall   = ((state == RUN) && hz_if.ex_md_start) ||
                      ((state == MD_BUSY) && !md_zero);
  assign branch_eff = (state == RUN) && hz_if.ex_branch_taken;
  assign load_use   = hz_if.ex_mem_rd && (hz_if.ex_rt_addr != 5'd0) &&
                      ((hz_if.ex_rt_addr == hz_if.id_rs_addr) ||
                       (hz_if.id_uses_rt && (hz_if.ex_rt_addr == hz_if.id_rt_addr)));

  md_occupancy_cnt #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (md_load),
    .dec    (md_dec),
    .zero_c (md_zero)
  );

  // Mult/div occupancy FSM; md_busy mirrors the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      md_busy <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (md_load) begin
            state   <= MD_BUSY;
            md_busy <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_zero) begin
            state   <= RUN;
            md_busy <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

  // Priority-ordered hazard controls, forced to normal while in reset.
  always_comb begin
    pc_hz_c     = HZ_NORMAL;
    if_id_hz_c  = HZ_NORMAL;
    id_ex_hz_c  = HZ_NORMAL;
    ex_mem_hz_c = HZ_NORMAL;
    if (rst_n) begin
      if (hz_if.mem_wait) begin
        pc_hz_c     = HZ_STALL;
        if_id_hz_c  = HZ_STALL;
        id_ex_hz_c  = HZ_STALL;
        ex_mem_hz_c = HZ_STALL;
      end else if (md_stall) begin
        pc_hz_c     = HZ_STALL;
        if_id_hz_c  = HZ_STALL;
        id_ex_hz_c  = HZ_STALL;
        ex_mem_hz_c = HZ_FLUSH;
      end else if (branch_eff) begin
        if_id_hz_c  = HZ_FLUSH;
        id_ex_hz_c  = HZ_FLUSH;
      end else if (load_use) begin
        pc_hz_c     = HZ_STALL;
        if_id_hz_c  = HZ_STALL;
        id_ex_hz_c  = HZ_FLUSH;
      end else if (hz_if.id_jump) begin
        if_id_hz_c  = HZ_FLUSH;
      end
    end
  end

  assign hz_if.pc_hz     = pc_hz_c;
  assign hz_if.if_id_hz  = if_id_hz_c;
  assign hz_if.id_ex_hz  = id_ex_hz_c;
  assign hz_if.ex_mem_hz = ex_mem_hz_c;

  // Saturating count of PC-hold cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((pc_hz_c == HZ_STALL) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Instance A: short mult/div and narrow counter; instance B: longer mult/div.
  hazard_ctrl_if if_a ();
  hazard_ctrl_if if_b ();
  logic       md_busy_a;
  logic [3:0] stall_a;
  logic       md_busy_b;
  logic [31:0] stall_b;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz_if        (if_a),
    .md_busy      (md_busy_a),
    .stall_cycles (stall_a)
  );

  hazard_ctrl #(.MD_LATENCY(8), .CNT_W(32)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz_if        (if_b),
    .md_busy      (md_busy_b),
    .stall_cycles (stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       mrd;
    logic [4:0] ert;
    logic       br;
    logic       jmp;
    logic       st;
    logic       mw;
    logic [7:0] exp;
  } vec_t;

  // Packed {pc, if_id, id_ex, ex_mem} expectations.
  localparam logic [7:0] E_NONE = 8'b00_00_00_00;
  localparam logic [7:0] E_LU   = 8'b10_10_01_00;
  localparam logic [7:0] E_BR   = 8'b00_01_01_00;
  localparam logic [7:0] E_JMP  = 8'b00_01_00_00;
  localparam logic [7:0] E_FRZ  = 8'b10_10_10_10;
  localparam logic [7:0] E_MD   = 8'b10_10_10_01;

  vec_t vecs[10];

  function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic uses,
                              logic mrd, logic [4:0] ert, logic br, logic jmp,
                              logic st, logic mw, logic [7:0] e);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.uses = uses; v.mrd = mrd; v.ert = ert;
    v.br = br; v.jmp = jmp; v.st = st; v.mw = mw; v.exp = e;
    return v;
  endfunction

  function automatic logic [7:0] hz_a();
    return {if_a.pc_hz, if_a.if_id_hz, if_a.id_ex_hz, if_a.ex_mem_hz};
  endfunction

  function automatic logic [7:0] hz_b();
    return {if_b.pc_hz, if_b.if_id_hz, if_b.id_ex_hz, if_b.ex_mem_hz};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_a(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mrd, input logic [4:0] ert, input logic br,
                       input logic jmp, input logic st, input logic mw);
    if_a.id_rs_addr = rs; if_a.id_rt_addr = rt; if_a.id_uses_rt = uses;
    if_a.ex_mem_rd = mrd; if_a.ex_rt_addr = ert; if_a.ex_branch_taken = br;
    if_a.id_jump = jmp; if_a.ex_md_start = st; if_a.mem_wait = mw;
  endtask

  task automatic idle_b();
    if_b.id_rs_addr = '0; if_b.id_rt_addr = '0; if_b.id_uses_rt = 1'b0;
    if_b.ex_mem_rd = 1'b0; if_b.ex_rt_addr = '0; if_b.ex_branch_taken = 1'b0;
    if_b.id_jump = 1'b0; if_b.ex_md_start = 1'b0; if_b.mem_wait = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 3 units later.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    set_a(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_b();
    rst_n = 1'b0;
    adv();
    adv();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_a(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_b();

    vecs[0] = mk("idle",          5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    vecs[1] = mk("lu_rs",         5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
    vecs[2] = mk("lu_addr0",      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    vecs[3] = mk("lu_rt_unused",  5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    vecs[4] = mk("lu_rt_used",    5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
    vecs[5] = mk("br_lu_jmp",     5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E_BR);
    vecs[6] = mk("jump",          5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_JMP);
    vecs[7] = mk("mw_over_br",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_FRZ);
    vecs[8] = mk("mw_over_start", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_FRZ);
    vecs[9] = mk("no_load",       5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);

    // Reset state
    #2;
    chk("rst_hz_a", 32'(hz_a()), 32'(E_NONE));
    chk("rst_busy_a", 32'(md_busy_a), 32'd0);
    chk("rst_stall_a", 32'(stall_a), 32'd0);
    adv();
    rst_n = 1'b1;

    // Single-cycle vectors in RUN
    for (int i = 0; i < 10; i++) begin
      set_a(vecs[i].rs, vecs[i].rt, vecs[i].uses, vecs[i].mrd, vecs[i].ert,
            vecs[i].br, vecs[i].jmp, vecs[i].st, vecs[i].mw);
      settle();
      chk(vecs[i].name, 32'(hz_a()), 32'(vecs[i].exp));
      adv();
    end
    chk("table_busy", 32'(md_busy_a), 32'd0);
    chk("table_stalls", 32'(stall_a), 32'd4);

    // Mult/div held start, latency 4
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_a(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, (c < 5) ? 1'b1 : 1'b0, 1'b0);
      settle();
      chk($sformatf("md_hz_c%0d", c), 32'(hz_a()), 32'((c < 4) ? E_MD : E_NONE));
      chk($sformatf("md_busy_c%0d", c), 32'(md_busy_a), 32'((c >= 1 && c <= 4) ? 1 : 0));
      if (c == 5) chk("md_stalls", 32'(stall_a), 32'd4);
      adv();
    end

    // Mult/div with memory wait on cycles 1-2; branch ignored on release
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_a(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, (c == 4) ? 1'b1 : 1'b0, 1'b0,
            (c < 5) ? 1'b1 : 1'b0, (c == 1 || c == 2) ? 1'b1 : 1'b0);
      settle();
      chk($sformatf("mdw_hz_c%0d", c), 32'(hz_a()),
          32'((c == 1 || c == 2) ? E_FRZ : ((c < 4) ? E_MD : E_NONE)));
      chk($sformatf("mdw_busy_c%0d", c), 32'(md_busy_a), 32'((c >= 1 && c <= 4) ? 1 : 0));
      if (c == 5) chk("mdw_stalls", 32'(stall_a), 32'd4);
      adv();
    end

    // Stall counter saturation
    do_reset();
    set_a(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      adv();
      if (c == 14) chk("sat_at_15", 32'(stall_a), 32'd15);
    end
    settle();
    chk("sat_hold", 32'(stall_a), 32'd15);
    adv();

    // Reset in the middle of a latency-8 mult/div
    do_reset();
    if_b.ex_md_start = 1'b1;
    settle();
    chk("rmid_start_hz", 32'(hz_b()), 32'(E_MD));
    adv();
    adv();
    adv();
    chk("rmid_busy", 32'(md_busy_b), 32'd1);
    chk("rmid_stalls", 32'(stall_b), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rmid_rst_busy", 32'(md_busy_b), 32'd0);
    chk("rmid_rst_hz", 32'(hz_b()), 32'(E_NONE));
    chk("rmid_rst_stalls", 32'(stall_b), 32'd0);
    if_b.ex_md_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    adv();
    settle();
    chk("rmid_post_hz", 32'(hz_b()), 32'(E_NONE));
    chk("rmid_post_busy", 32'(md_busy_b), 32'd0);
    adv();
    chk("rmid_post_stalls", 32'(stall_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
